// File: rtl/rega_pkg.sv
// rega_pkg: shared types and constants for the irrigation actuator sequencer.
//   state_t      : sequencer state encoding (3 bits, also exported on state_o)
//   FC_*         : fault_code values reported while latched in FAULT
//   is_run()     : true for the states in which an irrigation run is active
package rega_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        SPRINKLE = 3'd2,
        DRIP     = 3'd3,
        COOLDOWN = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ERRO    = 2'b01;
    localparam logic [1:0] FC_DRY     = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    // A run covers the valve-settle phase, the sprinkler phase and the drip phase.
    function automatic logic is_run(input state_t s);
        return (s == SETTLE) || (s == SPRINKLE) || (s == DRIP);
    endfunction

endpackage

// File: rtl/rega_tick_cnt.sv
// rega_tick_cnt: tick-gated up-counter with clear, optional saturation and a
// terminal-value compare.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_tick       : one-clk timing strobe; the count advances only on it
//   i_en         : count enable; while low the count is held at zero
//   i_clr        : synchronous clear, wins over i_tick
//   i_sat_en     : when high the count stops at i_sat_val
//   i_sat_val    : saturation value
//   i_term_val   : value compared against the current count
//   o_term_c     : combinational flag, count == i_term_val
module rega_tick_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_sat_en,
    input  logic [CNT_W-1:0] i_sat_val,
    input  logic [CNT_W-1:0] i_term_val,
    output logic             o_term_c
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_sat;

    assign w_at_sat = i_sat_en && (r_cnt == i_sat_val);

    // Count register: clear/disable first, then tick-gated increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (i_tick && !w_at_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_term_c = (r_cnt == i_term_val);

endmodule

// File: rtl/rega_atuador.sv
// rega_atuador: irrigation actuator sequencer. Turns the sprinkler (bs_req)
// and drip (vs_req) requests into pump/valve drives with valve-before-pump
// settling, minimum on-time, post-run cooldown, dry-run protection and a
// latched fault. All timing is counted in tick strobes.
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick         : one-clk timing strobe
//   bs_req       : sprinkler request (level)
//   vs_req       : drip request (level)
//   level_ok     : reservoir level sufficient
//   erro         : sensor/system error
//   fault_clr    : one-clk pulse clearing the latched fault
//   pump_en      : sprinkler pump drive
//   spr_valve    : sprinkler valve drive
//   drip_valve   : drip valve drive
//   busy         : sequencer not idle
//   fault        : latched fault
//   fault_code   : 00 none, 01 erro, 10 dry-run, 11 timeout
//   state_o      : current state encoding (debug)
// Build option: define RUN_TIMEOUT_EN to add the run-length timeout
// (FAULT/11 after MAX_ON_TICKS run ticks).
module rega_atuador
    import rega_pkg::*;
#(
    parameter int unsigned SETTLE_TICKS   = 3,
    parameter int unsigned MIN_ON_TICKS   = 5,
    parameter int unsigned COOLDOWN_TICKS = 4,
    parameter int unsigned MAX_ON_TICKS   = 10,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       bs_req,
    input  logic       vs_req,
    input  logic       level_ok,
    input  logic       erro,
    input  logic       fault_clr,
    output logic       pump_en,
    output logic       spr_valve,
    output logic       drip_valve,
    output logic       busy,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state_o
);

    // Reject tick settings the counter cannot represent or that would underflow.
    if ((SETTLE_TICKS < 1) || (COOLDOWN_TICKS < 1) || (MAX_ON_TICKS < 1) ||
        ((SETTLE_TICKS >> CNT_W) != 0) || ((MIN_ON_TICKS >> CNT_W) != 0) ||
        ((COOLDOWN_TICKS >> CNT_W) != 0) || ((MAX_ON_TICKS >> CNT_W) != 0))
    begin : g_bad_cfg
        $error("rega_atuador: tick parameters out of range for CNT_W");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       w_fault_src;

    logic             w_run;
    logic             w_phase_en;
    logic             w_phase_sat;
    logic             w_state_chg;
    logic             w_phase_term;
    logic [CNT_W-1:0] w_term_val;
    logic             w_timeout;

    logic             w_pump_en;
    logic             w_spr_valve;
    logic             w_drip_valve;
    logic             w_busy;
    logic             w_fault;
    logic [1:0]       w_fault_code;

    logic             r_pump_en;
    logic             r_spr_valve;
    logic             r_drip_valve;
    logic             r_busy;
    logic             r_fault;
    logic [1:0]       r_fault_code;

    // ------------------------------------------------------------------
    // Phase counter: ticks spent in the current state, restarted on every
    // state change; held at min-on once reached so a late drop exits at once.
    // ------------------------------------------------------------------
    assign w_run       = is_run(r_state);
    assign w_phase_en  = w_run || (r_state == COOLDOWN);
    assign w_phase_sat = (r_state == SPRINKLE) || (r_state == DRIP);
    assign w_state_chg = (w_next_state != r_state);

    // Per-state terminal value for the phase counter.
    always_comb begin
        w_term_val = '0;
        case (r_state)
            SETTLE:         w_term_val = CNT_W'(SETTLE_TICKS - 1);
            SPRINKLE, DRIP: w_term_val = CNT_W'(MIN_ON_TICKS);
            COOLDOWN:       w_term_val = CNT_W'(COOLDOWN_TICKS - 1);
            default:        w_term_val = '0;
        endcase
    end

    rega_tick_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tick     (tick),
        .i_en       (w_phase_en),
        .i_clr      (w_state_chg),
        .i_sat_en   (w_phase_sat),
        .i_sat_val  (CNT_W'(MIN_ON_TICKS)),
        .i_term_val (w_term_val),
        .o_term_c   (w_phase_term)
    );

`ifdef RUN_TIMEOUT_EN
    // Run-length counter: spans SETTLE+SPRINKLE as one run, or DRIP; fires on
    // the tick that completes MAX_ON_TICKS run ticks.
    logic w_to_term;

    rega_tick_cnt #(
        .CNT_W (CNT_W)
    ) u_timeout_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tick     (tick),
        .i_en       (w_run),
        .i_clr      (1'b0),
        .i_sat_en   (1'b1),
        .i_sat_val  (CNT_W'(MAX_ON_TICKS)),
        .i_term_val (CNT_W'(MAX_ON_TICKS - 1)),
        .o_term_c   (w_to_term)
    );

    assign w_timeout = tick && w_to_term;
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Inside a run the fault exits are checked first, so
    // they override min-on and win over a coincident tick.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_fault_src  = FC_NONE;
        case (r_state)
            IDLE: begin
                if (erro) begin
                    w_next_state = FAULT;
                    w_fault_src  = FC_ERRO;
                end else if (bs_req && level_ok) begin
                    w_next_state = SETTLE;
                end else if (vs_req && level_ok) begin
                    w_next_state = DRIP;
                end
            end
            SETTLE, SPRINKLE, DRIP: begin
                if (erro) begin
                    w_next_state = FAULT;
                    w_fault_src  = FC_ERRO;
                end else if (!level_ok) begin
                    w_next_state = FAULT;
                    w_fault_src  = FC_DRY;
                end else if (w_timeout) begin
                    w_next_state = FAULT;
                    w_fault_src  = FC_TIMEOUT;
                end else if (r_state == SETTLE) begin
                    // A dropped request during settling aborts before the pump starts.
                    if (!bs_req) begin
                        w_next_state = COOLDOWN;
                    end else if (tick && w_phase_term) begin
                        w_next_state = SPRINKLE;
                    end
                end else if (r_state == SPRINKLE) begin
                    if (!bs_req && w_phase_term) begin
                        w_next_state = COOLDOWN;
                    end
                end else begin
                    if (!vs_req && w_phase_term) begin
                        w_next_state = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                if (erro) begin
                    w_next_state = FAULT;
                    w_fault_src  = FC_ERRO;
                end else if (tick && w_phase_term) begin
                    w_next_state = IDLE;
                end
            end
            FAULT: begin
                if (fault_clr && !erro) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so the registered drives change on
    // the same edge as the state. The fault code is captured on entry to
    // FAULT and frozen until the fault is cleared.
    // ------------------------------------------------------------------
    always_comb begin
        w_pump_en    = (w_next_state == SPRINKLE);
        w_spr_valve  = (w_next_state == SETTLE) || (w_next_state == SPRINKLE);
        w_drip_valve = (w_next_state == DRIP);
        w_busy       = (w_next_state != IDLE);
        w_fault      = (w_next_state == FAULT);
        w_fault_code = FC_NONE;
        if (w_next_state == FAULT) begin
            w_fault_code = (r_state == FAULT) ? r_fault_code : w_fault_src;
        end
    end

    // Output registers; reset drops every drive asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pump_en    <= 1'b0;
            r_spr_valve  <= 1'b0;
            r_drip_valve <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            r_pump_en    <= w_pump_en;
            r_spr_valve  <= w_spr_valve;
            r_drip_valve <= w_drip_valve;
            r_busy       <= w_busy;
            r_fault      <= w_fault;
            r_fault_code <= w_fault_code;
        end
    end

    assign pump_en    = r_pump_en;
    assign spr_valve  = r_spr_valve;
    assign drip_valve = r_drip_valve;
    assign busy       = r_busy;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign state_o    = r_state;

endmodule

// File: tb/tb_rega_atuador.sv
// tb_rega_atuador: directed scenarios followed by a randomized run, each clock
// compared against a behavioural model of the sequencer (remaining-tick
// bookkeeping rather than state-machine encoding).
module tb_rega_atuador;
    import rega_pkg::*;

    localparam int unsigned SETTLE = 3;
    localparam int unsigned MIN_ON = 5;
    localparam int unsigned COOL   = 4;
    localparam int unsigned MAX_ON = 10;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       bs_req;
    logic       vs_req;
    logic       level_ok;
    logic       erro;
    logic       fault_clr;
    logic       pump_en;
    logic       spr_valve;
    logic       drip_valve;
    logic       busy;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] state_o;

    int n_checks;
    int n_errors;
    int g_cyc;
    int g_ticks;
    int g_t_settle;
    int g_t_pump;
    int g_t_cool;
    int g_t_drip;
    int t0;
    bit seen_drip;

    // Behavioural model
    bit         m_spr;
    bit         m_pump;
    bit         m_drip;
    bit         m_cool;
    bit         m_fault;
    logic [1:0] m_code;
    int         m_settle_left;
    int         m_on;
    int         m_cool_left;
    int         m_run;

    rega_atuador #(
        .SETTLE_TICKS   (SETTLE),
        .MIN_ON_TICKS   (MIN_ON),
        .COOLDOWN_TICKS (COOL),
        .MAX_ON_TICKS   (MAX_ON),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .bs_req     (bs_req),
        .vs_req     (vs_req),
        .level_ok   (level_ok),
        .erro       (erro),
        .fault_clr  (fault_clr),
        .pump_en    (pump_en),
        .spr_valve  (spr_valve),
        .drip_valve (drip_valve),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {1'b0, pump_en, spr_valve, drip_valve, busy, fault, fault_code};
    endfunction

    function automatic logic [7:0] m_vec();
        logic m_busy;
        m_busy = m_spr || m_drip || m_cool || m_fault;
        return {1'b0, m_pump, m_spr, m_drip, m_busy, m_fault, m_code};
    endfunction

    task automatic model_reset();
        m_spr = 0; m_pump = 0; m_drip = 0; m_cool = 0; m_fault = 0;
        m_code = 2'b00; m_settle_left = 0; m_on = 0; m_cool_left = 0; m_run = 0;
    endtask

    task automatic go_fault(input logic [1:0] c);
        m_spr = 0; m_pump = 0; m_drip = 0; m_cool = 0;
        m_fault = 1; m_code = c;
    endtask

    task automatic start_cool();
        m_spr = 0; m_pump = 0; m_drip = 0;
        m_cool = 1; m_cool_left = int'(COOL);
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        bit req;
        bit fire_to;
        if (!rst_n) begin
            model_reset();
        end else if (m_fault) begin
            if (fault_clr && !erro) begin
                m_fault = 0;
                m_code  = 2'b00;
            end
        end else if (m_cool) begin
            if (erro) go_fault(2'b01);
            else if (tick) begin
                m_cool_left--;
                if (m_cool_left == 0) m_cool = 0;
            end
        end else if (m_spr || m_drip) begin
            req     = m_drip ? vs_req : bs_req;
            fire_to = 0;
`ifdef RUN_TIMEOUT_EN
            fire_to = tick && ((m_run + 1) >= int'(MAX_ON));
`endif
            if (erro) go_fault(2'b01);
            else if (!level_ok) go_fault(2'b10);
            else if (fire_to) go_fault(2'b11);
            else begin
                if (tick) m_run++;
                if (m_spr && !m_pump) begin
                    if (!bs_req) start_cool();
                    else if (tick) begin
                        m_settle_left--;
                        if (m_settle_left == 0) begin
                            m_pump = 1;
                            m_on   = 0;
                        end
                    end
                end else begin
                    if (!req && (m_on == int'(MIN_ON))) start_cool();
                    else if (tick && (m_on < int'(MIN_ON))) m_on++;
                end
            end
        end else begin
            if (erro) go_fault(2'b01);
            else if (bs_req && level_ok) begin
                m_spr = 1; m_settle_left = int'(SETTLE); m_run = 0;
            end else if (vs_req && level_ok) begin
                m_drip = 1; m_on = 0; m_run = 0;
            end
        end
    endtask

    // One clock: drive tick, advance DUT and model, compare all outputs.
    task automatic cyc();
        tick = ((g_cyc % 4) == 3);
        if (tick) begin
            g_ticks++;
            if (spr_valve && !pump_en) g_t_settle++;
            if (pump_en) g_t_pump++;
            if (busy && !spr_valve && !drip_valve && !fault) g_t_cool++;
            if (drip_valve) g_t_drip++;
        end
        @(posedge clk);
        model_step();
        #1;
        g_cyc++;
        chk("model", dut_vec(), m_vec());
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 400 && busy; k++) cyc();
        chk(tag, {7'b0, busy}, 8'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; g_cyc = 0; g_ticks = 0;
        g_t_settle = 0; g_t_pump = 0; g_t_cool = 0; g_t_drip = 0;
        rst_n = 1'b0; tick = 1'b0; bs_req = 1'b0; vs_req = 1'b0;
        level_ok = 1'b0; erro = 1'b0; fault_clr = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("reset_outputs", dut_vec(), 8'd0);
        chk("reset_state", {5'b0, state_o}, {5'b0, IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Sprinkler run: settle, min-on honoured after drop, cooldown
        level_ok = 1'b1; bs_req = 1'b1; g_t_settle = 0;
        cyc();
        chk("spr_valve_next_clk", {7'b0, spr_valve}, 8'd1);
        for (int k = 0; k < 100 && !pump_en; k++) cyc();
        chk("settle_ticks", 8'(g_t_settle), 8'(SETTLE));
        g_t_pump = 0; t0 = g_ticks;
        for (int k = 0; k < 100 && (g_ticks - t0) < 4; k++) cyc();
        bs_req = 1'b0;
        for (int k = 0; k < 100 && pump_en; k++) cyc();
        chk("min_on_ticks", 8'(g_t_pump), 8'(MIN_ON));
        g_t_cool = 0;
        wait_idle("spr_back_idle");
        chk("cooldown_ticks", 8'(g_t_cool), 8'(COOL));
        chk("idle_state", {5'b0, state_o}, {5'b0, IDLE});

        // Both requests: sprinkler wins, drip follows after cooldown
        bs_req = 1'b1; vs_req = 1'b1; seen_drip = 0;
        for (int k = 0; k < 100 && !pump_en; k++) begin cyc(); seen_drip |= drip_valve; end
        bs_req = 1'b0;
        for (int k = 0; k < 100 && pump_en; k++) begin cyc(); seen_drip |= drip_valve; end
        chk("no_drip_in_spr", {7'b0, seen_drip}, 8'd0);
        g_t_cool = 0;
        for (int k = 0; k < 200 && !drip_valve; k++) cyc();
        chk("drip_after_cool", {7'b0, drip_valve}, 8'd1);
        chk("cool_before_drip", 8'(g_t_cool), 8'(COOL));
        vs_req = 1'b0;
        wait_idle("drip_back_idle");

        // One-tick drip pulse held for min-on
        vs_req = 1'b1;
        for (int k = 0; k < 100 && !drip_valve; k++) cyc();
        g_t_drip = 0; t0 = g_ticks;
        for (int k = 0; k < 100 && (g_ticks - t0) < 1; k++) cyc();
        vs_req = 1'b0;
        for (int k = 0; k < 100 && drip_valve; k++) cyc();
        chk("drip_min_on", 8'(g_t_drip), 8'(MIN_ON));
        wait_idle("pulse_back_idle");

        // Dry-run during sprinkling
        bs_req = 1'b1;
        for (int k = 0; k < 100 && !pump_en; k++) cyc();
        t0 = g_ticks;
        for (int k = 0; k < 100 && (g_ticks - t0) < 2; k++) cyc();
        level_ok = 1'b0;
        cyc();
        chk("dry_pump_off", {7'b0, pump_en}, 8'd0);
        chk("dry_fault", {7'b0, fault}, 8'd1);
        chk("dry_code", {6'b0, fault_code}, 8'd2);
        bs_req = 1'b0; fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        chk("dry_clear", {5'b0, fault, fault_code}, 8'd0);
        level_ok = 1'b1;
        cyc();

        // erro during drip, clear blocked while erro stays high
        vs_req = 1'b1;
        for (int k = 0; k < 100 && !drip_valve; k++) cyc();
        erro = 1'b1;
        cyc();
        chk("erro_fault", {5'b0, fault, fault_code}, 8'b0000_0101);
        chk("erro_drip_off", {7'b0, drip_valve}, 8'd0);
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        chk("clr_ignored", {5'b0, fault, fault_code}, 8'b0000_0101);
        erro = 1'b0; vs_req = 1'b0;
        cyc();
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        chk("erro_clear", {4'b0, busy, fault, fault_code}, 8'd0);

        // Asynchronous reset mid-sprinkle
        bs_req = 1'b1;
        for (int k = 0; k < 100 && !pump_en; k++) cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", dut_vec(), 8'd0);
        model_reset();
        bs_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("no_cool_after_rst", {7'b0, busy}, 8'd0);

        // Long sprinkler hold: timeout fault or indefinite run
        bs_req = 1'b1;
        for (int k = 0; k < 100 && !pump_en; k++) cyc();
        t0 = g_ticks;
        for (int k = 0; k < 200 && (g_ticks - t0) < 15; k++) cyc();
`ifdef RUN_TIMEOUT_EN
        chk("timeout_fault", {5'b0, fault, fault_code}, 8'b0000_0111);
`else
        chk("hold_pump_on", {7'b0, pump_en}, 8'd1);
`endif
        bs_req = 1'b0; fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        wait_idle("hold_back_idle");

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(11) == 0) bs_req = ~bs_req;
            if ($urandom_range(11) == 0) vs_req = ~vs_req;
            if ($urandom_range(29) == 0) level_ok = ~level_ok;
            if ($urandom_range(59) == 0) erro = ~erro;
            fault_clr = ($urandom_range(5) == 0);
            cyc();
        end

        // Drain back to idle
        bs_req = 1'b0; vs_req = 1'b0; erro = 1'b0; level_ok = 1'b1;
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        wait_idle("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
